note_detector: RTL and testbench
================================

// Module: note_detector
// PURPOSE
//  Receive-side counterpart of the song player: measures the half-period of an incoming square-wave tone
//  and matches it against the note table. The table uses the same half-period encoding the player uses.
//  Reports the matched note index and raises a one-cycle strobe on each new note.
//  It is used for loopback self-test of the speaker path and for transcribing an external tone source.
// PARAMETERS
//  CNT_W       15                  width of half-period counter and note values (matches player counter)
//  NUM_NOTES   16                  note table entries; IDX_W = $clog2(NUM_NOTES)
//  TOL         4                   max |measured - table| (clocks) counted as a match/agreement
//  STABLE_N    3                   consecutive agreeing measurements required before lookup
//  SILENCE_CYC 2**CNT_W-1          half-period counter saturation = silence timeout (clocks)
//  TABLE_FILE  "note_table.txt"    $readmemb file, NUM_NOTES x CNT_W-bit half-period values
// PORTS
//  clk          in   1      single system clock; all logic on posedge
//  reset        in   1      synchronous, active-high reset
//  tone_in      in   1      asynchronous square-wave input
//  note_idx     out  IDX_W  index of the locked table entry
//  note_value   out  CNT_W  measured half-period value captured at lock
//  note_valid   out  1      a note is currently locked
//  note_strobe  out  1      one-cycle pulse when a lock yields a new note
//  silence      out  1      no edge seen for SILENCE_CYC clocks
// BEHAVIOUR
//  Reset (sync, high): FSM=SILENT, syncs/counters=0, note_idx=0, note_value=0, note_valid=0,
//   note_strobe=0, silence=1. A reset asserted in any state, including mid-SCAN, takes effect the next cycle.
//  Input: 2-FF synchronizer, 3rd FF for edge detect. edge = s2^s3 (both polarities).
//   tone_in transition -> edge is high 3 clocks later.
//  Half counter hc: edge -> hc<=0; else hc<=hc+1, saturating at SILENCE_CYC.
//   On edge, m = hc. A player value V (half period V+1 clocks) therefore yields m = V exactly.
//  Valid measurement: an edge with m < SILENCE_CYC, excluding the first edge after reset/SILENT
//   (a partial period, which is discarded).
//  Agreement: |m - m_prev| <= TOL, computed as unsigned abs diff in CNT_W+1 bits.
//   First valid m: stab_cnt=1. Agreeing m: stab_cnt+1, saturating at STABLE_N. Disagreeing m: stab_cnt=1.
//   m_prev <= m on every valid measurement.
//  FSM:
//   SILENT:  silence=1, note_valid=0. On edge: silence<=0, discard m -> MEASURE.
//   MEASURE: update stab_cnt. When stab_cnt reaches STABLE_N: m_lat<=m, i<=0 -> SCAN.
//   SCAN:    one table entry per cycle (combinational ROM read of T[i]).
//            If |T[i]-m_lat|<=TOL, the first (lowest-index) match wins: note_idx<=i, note_value<=m_lat,
//             note_valid<=1. note_strobe<=1 for one cycle iff !note_valid or i!=note_idx. -> LOCKED.
//            If i==NUM_NOTES-1 with no match: note_valid<=0, stab_cnt<=0 -> MEASURE.
//            Edges during SCAN update m_prev/stab_cnt but do not restart the scan.
//            Worst-case scan is NUM_NOTES cycles.
//   LOCKED:  each valid m compared to note_value. Within TOL: hold, no strobe.
//            Outside TOL: note_valid<=0, stab_cnt<=1 -> MEASURE.
//  Silence: hc==SILENCE_CYC with no edge in any non-SILENT state -> SILENT next cycle:
//   note_valid<=0, silence<=1, note_idx/note_value hold. This rule takes priority over FSM transitions.
//  Edge in the same cycle hc saturates: m invalid, treated as the first edge (discarded).
//  Latency to lock: 4 edges (1 discarded + STABLE_N) + 3 sync + <=NUM_NOTES scan + 1 output register.
//  Table constraint: entries > NUM_NOTES+TOL and pairwise separated by > 2*TOL.
//   This makes a match unique and guarantees no edge arrives mid-scan for tabled notes.
//  All outputs registered; note_strobe never high for 2 consecutive cycles.
// STRUCTURE
//  note_pkg: CNT_W, NUM_NOTES, IDX_W, TOL defaults; state enum {SILENT,MEASURE,SCAN,LOCKED};
//   function abs_diff(a,b) returning CNT_W+1 bits.
//  Sub-module note_table_rom (TABLE_FILE, $readmemb, async read: addr IDX_W -> data CNT_W).
//   The same table file is shared with the song player build.
//  Top holds synchronizer, hc, stability tracker, FSM; ~200 lines.
// TESTING
//  1 Reset held 2 clk, tone_in=0 -> silence=1, note_valid=0, note_strobe=0, note_idx=0, note_value=0.
//  2 T[5]=99; drive half period 100 clk -> after 4th edge + <=20 clk: note_idx=5, note_value=99,
//    note_valid=1, exactly one note_strobe.
//  3 Locked on 99, alternate half periods 100/103 clk (m=99/102) -> stays LOCKED, no further strobe.
//    Then switch to m=150 with T[7]=150 -> note_valid drops, relock to idx 7 with one strobe.
//  4 Half period giving m=500, in no table entry -> note_valid stays 0, no strobe ever, silence=0.
//  5 Locked, then tone_in static -> silence=1, note_valid=0 exactly SILENCE_CYC+1 clk after the last edge.
//    Resume m=99 -> relock idx 5 with a fresh strobe.
//  6 Assert reset during SCAN -> next cycle all outputs at reset values; no strobe emitted after reset.

Source files
------------

// File: rtl/note_detector_pkg.sv
// Shared constants, FSM state type and helpers for the tone note detector.
// Sizing matches the song player so that both use the same half-period table.
package note_detector_pkg;

    localparam int unsigned CNT_W     = 15;
    localparam int unsigned NUM_NOTES = 16;
    localparam int unsigned IDX_W     = $clog2(NUM_NOTES);
    localparam int unsigned TOL       = 4;
    localparam int unsigned STABLE_N  = 3;

    typedef logic [0:NUM_NOTES-1][CNT_W-1:0] note_table_t;

    // Half-period values (clocks minus one); entries > NUM_NOTES+TOL, spaced > 2*TOL apart.
    localparam note_table_t DEFAULT_TABLE = {
        15'd40,  15'd50,  15'd60,  15'd70,  15'd85,  15'd99,  15'd120, 15'd150,
        15'd180, 15'd210, 15'd250, 15'd300, 15'd350, 15'd400, 15'd450, 15'd600
    };

    typedef enum logic [1:0] {
        StSilent,
        StMeasure,
        StScan,
        StLocked
    } state_e;

    function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
        return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
    endfunction

endpackage

// File: rtl/note_detector_if.sv
// Tone input and note report outputs of the note detector.
// master: the detector itself; slave: whoever drives the tone and consumes notes.
interface note_detector_if;
    import note_detector_pkg::*;

    logic             tone_in;
    logic [IDX_W-1:0] note_idx;
    logic [CNT_W-1:0] note_value;
    logic             note_valid;
    logic             note_strobe;
    logic             silence;

    modport master (
        input  tone_in,
        output note_idx,
        output note_value,
        output note_valid,
        output note_strobe,
        output silence
    );

    modport slave (
        output tone_in,
        input  note_idx,
        input  note_value,
        input  note_valid,
        input  note_strobe,
        input  silence
    );

endinterface

// File: rtl/note_detector_table_rom.sv
// Asynchronous-read note table holding the half-period encoding shared with the player.
// Contents are supplied as a parameter generated from the common table file.
module note_detector_table_rom
    import note_detector_pkg::*;
#(
    parameter note_table_t NoteTable = DEFAULT_TABLE
) (
    input  logic [IDX_W-1:0] addr_i,
    output logic [CNT_W-1:0] data_o
);

    assign data_o = NoteTable[addr_i];

endmodule

// File: rtl/note_detector.sv
// Measures the half-period of an asynchronous square wave, waits for it to settle,
// then scans the note table one entry per cycle and reports the matching note.
module note_detector
    import note_detector_pkg::*;
#(
    parameter int unsigned Tol       = TOL,
    parameter int unsigned StableN   = STABLE_N,
    parameter note_table_t NoteTable = DEFAULT_TABLE
) (
    input  logic             clk,
    input  logic             reset,
    note_detector_if.master  bus
);

    localparam int unsigned      STAB_W      = $clog2(StableN + 1);
    localparam logic [STAB_W-1:0] STAB_MAX   = STAB_W'(StableN);
    localparam logic [CNT_W-1:0] SILENCE_CYC = '1;
    localparam logic [CNT_W:0]   TOL_W       = (CNT_W + 1)'(Tol);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_NOTES - 1);

    logic              s1_q, s2_q, s3_q;
    logic [CNT_W-1:0]  hc_q, hc_d;
    logic [CNT_W-1:0]  m_prev_q, m_prev_d;
    logic [CNT_W-1:0]  m_lat_q, m_lat_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  value_q, value_d;
    logic              valid_q, valid_d;
    logic              strobe_q, strobe_d;
    logic              silence_q, silence_d;

    logic              tone_edge;
    logic              hc_sat;
    logic              meas_valid;
    logic              agree;
    logic [STAB_W-1:0] stab_next;
    logic [CNT_W-1:0]  rom_data;
    logic              table_match;
    logic              hold_match;

    note_detector_table_rom #(
        .NoteTable (NoteTable)
    ) u_rom (
        .addr_i (scan_idx_q),
        .data_o (rom_data)
    );

    assign tone_edge   = s2_q ^ s3_q;
    assign hc_sat      = (hc_q == SILENCE_CYC);
    // The first edge after silence closes a partial period, so it never counts.
    assign meas_valid  = tone_edge && !hc_sat && (state_q != StSilent);
    assign agree       = (stab_q != '0) && (abs_diff(hc_q, m_prev_q) <= TOL_W);
    assign stab_next   = !agree ? STAB_W'(1) :
                         (stab_q == STAB_MAX) ? STAB_MAX : stab_q + 1'b1;
    assign table_match = (abs_diff(rom_data, m_lat_q) <= TOL_W);
    assign hold_match  = (abs_diff(hc_q, value_q) <= TOL_W);

    always_comb begin
        hc_d       = tone_edge ? '0 : (hc_sat ? hc_q : hc_q + 1'b1);
        m_prev_d   = m_prev_q;
        m_lat_d    = m_lat_q;
        stab_d     = stab_q;
        scan_idx_d = scan_idx_q;
        state_d    = state_q;
        idx_d      = idx_q;
        value_d    = value_q;
        valid_d    = valid_q;
        strobe_d   = 1'b0;
        silence_d  = silence_q;

        if (meas_valid) begin
            m_prev_d = hc_q;
            stab_d   = stab_next;
        end
        if (tone_edge && hc_sat && (state_q != StSilent)) begin
            stab_d = '0;
        end

        if ((state_q != StSilent) && hc_sat && !tone_edge) begin
            // Timeout overrides whatever the FSM was doing; the last note is kept for reference.
            state_d   = StSilent;
            valid_d   = 1'b0;
            silence_d = 1'b1;
            stab_d    = '0;
        end else begin
            unique case (state_q)
                StSilent: begin
                    if (tone_edge) begin
                        silence_d = 1'b0;
                        stab_d    = '0;
                        state_d   = StMeasure;
                    end
                end
                StMeasure: begin
                    if (meas_valid && (stab_next == STAB_MAX)) begin
                        m_lat_d    = hc_q;
                        scan_idx_d = '0;
                        state_d    = StScan;
                    end
                end
                StScan: begin
                    if (table_match) begin
                        idx_d    = scan_idx_q;
                        value_d  = m_lat_q;
                        valid_d  = 1'b1;
                        strobe_d = !valid_q || (scan_idx_q != idx_q);
                        state_d  = StLocked;
                    end else if (scan_idx_q == LAST_IDX) begin
                        valid_d = 1'b0;
                        stab_d  = '0;
                        state_d = StMeasure;
                    end else begin
                        scan_idx_d = scan_idx_q + 1'b1;
                    end
                end
                StLocked: begin
                    if (meas_valid && !hold_match) begin
                        valid_d = 1'b0;
                        stab_d  = STAB_W'(1);
                        state_d = StMeasure;
                    end
                end
                default: state_d = StSilent;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            hc_q       <= '0;
            m_prev_q   <= '0;
            m_lat_q    <= '0;
            stab_q     <= '0;
            scan_idx_q <= '0;
            state_q    <= StSilent;
            idx_q      <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            strobe_q   <= 1'b0;
            silence_q  <= 1'b1;
        end else begin
            s1_q       <= bus.tone_in;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            hc_q       <= hc_d;
            m_prev_q   <= m_prev_d;
            m_lat_q    <= m_lat_d;
            stab_q     <= stab_d;
            scan_idx_q <= scan_idx_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            strobe_q   <= strobe_d;
            silence_q  <= silence_d;
        end
    end

    assign bus.note_idx    = idx_q;
    assign bus.note_value  = value_q;
    assign bus.note_valid  = valid_q;
    assign bus.note_strobe = strobe_q;
    assign bus.silence     = silence_q;

endmodule

// File: tb/tb_note_detector.sv
// Directed bench for note_detector: expected notes are queued by the stimulus and
// popped by a monitor on every note_strobe; state checks are made inline.
module tb_note_detector;
    import note_detector_pkg::*;

    localparam int unsigned SIL = 2 ** CNT_W - 1;

    typedef struct {
        int unsigned idx;
        int unsigned value;
    } note_t;

    logic  clk   = 1'b0;
    logic  reset = 1'b1;
    int    checks = 0;
    int    errors = 0;
    note_t exp_q[$];
    logic  prev_strobe = 1'b0;

    note_detector_if bus ();

    note_detector u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Toggle tone_in, then hold for n clocks; repeated count times (half period n -> m = n-1).
    task automatic tone_period(input int n, input int count);
        for (int k = 0; k < count; k++) begin
            bus.tone_in = ~bus.tone_in;
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_note(input int unsigned idx, input int unsigned value);
        note_t e;
        e.idx   = idx;
        e.value = value;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        note_t e;
        if (bus.note_strobe) begin
            check("strobe_not_back_to_back", int'(prev_strobe), 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got strobe idx %0d value %0d, required none (t=%0t)",
                         bus.note_idx, bus.note_value, $time);
            end else begin
                e = exp_q.pop_front();
                check("strobe_idx", int'(bus.note_idx), e.idx);
                check("strobe_value", int'(bus.note_value), e.value);
                check("strobe_valid", int'(bus.note_valid), 1);
            end
        end
        prev_strobe = bus.note_strobe;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got timeout, required finish before limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        // Reset
        bus.tone_in = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_silence", int'(bus.silence), 1);
        check("reset_valid", int'(bus.note_valid), 0);
        check("reset_strobe", int'(bus.note_strobe), 0);
        check("reset_idx", int'(bus.note_idx), 0);
        check("reset_value", int'(bus.note_value), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Lock on m=99 -> idx 5 within 20 clocks of the 4th edge
        expect_note(5, 99);
        tone_period(100, 3);
        bus.tone_in = ~bus.tone_in;
        repeat (20) @(posedge clk);
        #1;
        check("lock99_valid", int'(bus.note_valid), 1);
        check("lock99_idx", int'(bus.note_idx), 5);
        check("lock99_value", int'(bus.note_value), 99);
        check("lock99_silence", int'(bus.silence), 0);
        repeat (80) @(posedge clk);
        #1;

        // Jitter 99/102 stays locked, then move to 150 -> idx 7
        for (int k = 0; k < 3; k++) begin
            tone_period(103, 1);
            tone_period(100, 1);
        end
        check("jitter_valid", int'(bus.note_valid), 1);
        check("jitter_idx", int'(bus.note_idx), 5);
        expect_note(7, 150);
        tone_period(151, 2);
        check("change_drop_valid", int'(bus.note_valid), 0);
        tone_period(151, 2);
        check("lock150_valid", int'(bus.note_valid), 1);
        check("lock150_idx", int'(bus.note_idx), 7);
        check("lock150_value", int'(bus.note_value), 150);

        // m=500 is in no table entry
        tone_period(501, 7);
        check("untabled_valid", int'(bus.note_valid), 0);
        check("untabled_silence", int'(bus.silence), 0);

        // Relock 99, then stop the tone and time the silence timeout
        expect_note(5, 99);
        tone_period(100, 3);
        bus.tone_in = ~bus.tone_in;
        repeat (3 + SIL) @(posedge clk);
        #1;
        check("pre_timeout_silence", int'(bus.silence), 0);
        check("pre_timeout_valid", int'(bus.note_valid), 1);
        @(posedge clk);
        #1;
        check("timeout_silence", int'(bus.silence), 1);
        check("timeout_valid", int'(bus.note_valid), 0);
        check("timeout_idx_hold", int'(bus.note_idx), 5);
        check("timeout_value_hold", int'(bus.note_value), 99);

        expect_note(5, 99);
        tone_period(100, 4);
        check("resume_valid", int'(bus.note_valid), 1);
        check("resume_idx", int'(bus.note_idx), 5);
        check("resume_silence", int'(bus.silence), 0);

        // Reset while scanning toward idx 7: no strobe may follow
        tone_period(151, 3);
        bus.tone_in = ~bus.tone_in;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("scan_reset_silence", int'(bus.silence), 1);
        check("scan_reset_valid", int'(bus.note_valid), 0);
        check("scan_reset_strobe", int'(bus.note_strobe), 0);
        check("scan_reset_idx", int'(bus.note_idx), 0);
        check("scan_reset_value", int'(bus.note_value), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("post_reset_valid", int'(bus.note_valid), 0);

        check("expected_notes_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
